// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch sequencer. Owns the fetch PC, addresses a
// combinational IMEM every cycle and buffers returned words in a small FIFO
// that decode drains through a valid/ready handshake. A redirect pulse from
// execute flushes the FIFO and restarts fetch from a new address.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   imem_addr    IMEM byte address (the fetch PC)
//   imem_data    IMEM word for imem_addr, same cycle
//   redirect     one-cycle flush/restart request
//   redirect_pc  restart address (bits [1:0] forced to 0)
//   inst_valid   head entry valid
//   inst         head entry instruction word
//   inst_pc      head entry byte address
//   inst_ready   decode accepts the head entry
//   level        number of occupied entries
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      r_fetch_pc;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_q_pc   [DEPTH];
  logic [31:0]      r_q_word [DEPTH];

  logic             w_pop;
  logic             w_push;
  logic [CNT_W-1:0] w_count_nxt;

  // A full queue still accepts a push when the head leaves on the same edge.
  assign w_pop  = inst_valid & inst_ready;
  assign w_push = !redirect & ((r_count < CNT_W'(DEPTH)) | w_pop);

  // Occupancy update for the non-redirect case.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Control state: redirect wins over push and pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= {RESET_PC[31:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Queue storage is not reset; contents are meaningless while count is 0.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_fetch_pc;
      r_q_word[r_wr_ptr] <= imem_data;
    end
  end

  assign imem_addr  = r_fetch_pc;
  assign inst_valid = (r_count != '0);
  assign inst       = r_q_word[r_rd_ptr];
  assign inst_pc    = r_q_pc[r_rd_ptr];
  assign level      = r_count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: streaming, stall/fill, full-queue
// pop+push, redirects, PC wraparound and asynchronous reset.
module tb_ifetch_queue;

  logic        clock;
  logic        reset0, reset1;
  logic [31:0] imem_addr0, imem_addr1;
  logic [31:0] imem_data0, imem_data1;
  logic        redirect0, redirect1;
  logic [31:0] redirect_pc0, redirect_pc1;
  logic        inst_valid0, inst_valid1;
  logic [31:0] inst0, inst1;
  logic [31:0] inst_pc0, inst_pc1;
  logic        inst_ready0, inst_ready1;
  logic [2:0]  level0, level1;

  int n_checks = 0;
  int n_errors = 0;

  // IMEM model: word at byte address A holds A/4.
  assign imem_data0 = imem_addr0 >> 2;
  assign imem_data1 = imem_addr1 >> 2;

  ifetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut0 (
    .clock(clock), .reset(reset0), .imem_addr(imem_addr0), .imem_data(imem_data0),
    .redirect(redirect0), .redirect_pc(redirect_pc0), .inst_valid(inst_valid0),
    .inst(inst0), .inst_pc(inst_pc0), .inst_ready(inst_ready0), .level(level0)
  );

  ifetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_dut1 (
    .clock(clock), .reset(reset1), .imem_addr(imem_addr1), .imem_data(imem_data1),
    .redirect(redirect1), .redirect_pc(redirect_pc1), .inst_valid(inst_valid1),
    .inst(inst1), .inst_pc(inst_pc1), .inst_ready(inst_ready1), .level(level1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs and checks happen at +1.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut0();
    reset0 = 1'b1;
    step();
    reset0 = 1'b0;
  endtask

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    redirect0 = 1'b0; redirect1 = 1'b0;
    redirect_pc0 = '0; redirect_pc1 = '0;
    inst_ready0 = 1'b1; inst_ready1 = 1'b0;
    step();

    // Reset state
    check("rst_valid", 32'(inst_valid0), 32'd0);
    check("rst_level", 32'(level0), 32'd0);
    check("rst_addr", imem_addr0, 32'h0);

    // Streaming with ready held high
    reset0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("stream_valid", 32'(inst_valid0), 32'd1);
      check("stream_pc", inst_pc0, 32'(4 * i));
      check("stream_inst", inst0, 32'(i));
      check("stream_level", 32'(level0), 32'd1);
    end

    // Stall: fill to DEPTH and hold
    inst_ready0 = 1'b0;
    reset_dut0();
    for (int k = 1; k <= 10; k++) begin
      step();
      check("fill_level", 32'(level0), 32'((k < 4) ? k : 4));
      check("fill_addr", imem_addr0, 32'(4 * ((k < 4) ? k : 4)));
      check("fill_head_pc", inst_pc0, 32'h0);
    end

    // Drain from full: pop+push every edge, no gaps
    inst_ready0 = 1'b1;
    for (int j = 0; j < 7; j++) begin
      check("drain_pc", inst_pc0, 32'(4 * j));
      check("drain_inst", inst0, 32'(j));
      step();
      check("drain_level", 32'(level0), 32'd4);
      check("drain_addr", imem_addr0, 32'(16 + 4 * (j + 1)));
    end

    // Redirect at level 3 with a simultaneous ready
    inst_ready0 = 1'b0;
    reset_dut0();
    repeat (3) step();
    check("pre_redir_level", 32'(level0), 32'd3);
    inst_ready0 = 1'b1;
    redirect0 = 1'b1;
    redirect_pc0 = 32'h0000_0103;
    step();
    redirect0 = 1'b0;
    check("redir_valid", 32'(inst_valid0), 32'd0);
    check("redir_level", 32'(level0), 32'd0);
    check("redir_addr", imem_addr0, 32'h100);
    step();
    check("redir_valid2", 32'(inst_valid0), 32'd1);
    check("redir_pc", inst_pc0, 32'h100);
    check("redir_inst", inst0, 32'h40);
    step();
    check("redir_next_pc", inst_pc0, 32'h104);

    // Back-to-back redirects
    redirect0 = 1'b1; redirect_pc0 = 32'h200;
    step();
    check("b2b_valid_a", 32'(inst_valid0), 32'd0);
    redirect_pc0 = 32'h301;
    step();
    redirect0 = 1'b0;
    check("b2b_valid_b", 32'(inst_valid0), 32'd0);
    check("b2b_addr", imem_addr0, 32'h300);
    step();
    check("b2b_pc", inst_pc0, 32'h300);
    check("b2b_valid_c", 32'(inst_valid0), 32'd1);

    // Asynchronous reset mid-cycle with level 2
    inst_ready0 = 1'b0;
    reset_dut0();
    repeat (2) step();
    check("pre_arst_level", 32'(level0), 32'd2);
    #2;
    reset0 = 1'b1;
    #1;
    check("arst_valid", 32'(inst_valid0), 32'd0);
    check("arst_level", 32'(level0), 32'd0);
    check("arst_addr", imem_addr0, 32'h0);
    step();
    reset0 = 1'b0;

    // PC wraparound from RESET_PC = FFFF_FFF8
    inst_ready1 = 1'b1;
    check("wrap_rst_addr", imem_addr1, 32'hFFFF_FFF8);
    reset1 = 1'b0;
    step();
    check("wrap_pc0", inst_pc1, 32'hFFFF_FFF8);
    step();
    check("wrap_pc1", inst_pc1, 32'hFFFF_FFFC);
    step();
    check("wrap_pc2", inst_pc1, 32'h0000_0000);
    step();
    check("wrap_pc3", inst_pc1, 32'h0000_0004);
    check("wrap_inst3", inst1, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
